aes_round_core: RTL and testbench
=================================

Name: aes_round_core

Overview:
Iterative AES-128 encryption datapath. It sits directly downstream of the key-expansion stage and consumes its 44-word round-key bus (11 round keys). One 128-bit block is encrypted per request, one round per clock, using a start/done handshake. The 16 S-boxes are built from the existing 32-bit subword S-box block, four instances in total.

Parameters:
NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
word  input  1408  round keys [0:1407] from key expansion; round key r = word[128r : 128r+127]; bit 0 = MSB
key_ready  input  1  high when all 44 words of word are valid and stable
start  input  1  request to encrypt plaintext; sampled on the rising edge
plaintext  input  128  [0:127]; byte 0 = bits 0:7; FIPS-197 column-major state order
busy  output  1  high while an encryption is in flight
ciphertext  output  128  [0:127]; result of the last completed encryption
done  output  1  one-cycle pulse when ciphertext updates

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, round counter=0, state register=0, ciphertext=0, busy=0, done=0.
- FSM states: IDLE, RUN.
- IDLE to RUN on the edge where start=1 and key_ready=1.
  - At that edge: state <= plaintext ^ rk0; round <= 1; busy <= 1.
- start is ignored while in RUN, and also ignored when key_ready=0.
  - An ignored start is dropped. It is not queued.
- plaintext is sampled only at the accepting edge. Later changes to it have no effect.
- RUN with round 1..9, per edge:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[round]
  - round <= round+1
- RUN with round 10, at that edge:
  - ciphertext <= ShiftRows(SubBytes(state)) ^ rk10 (no MixColumns)
  - done <= 1, busy <= 0, round <= 0, FSM to IDLE.
- done is high for exactly one cycle and is 0 on every other edge.
- Latency: start accepted at edge E; done and the new ciphertext are visible after edge E+10. busy is high for exactly 10 cycles.
- Back-to-back: start may be high in the cycle where done=1 (FSM already IDLE). It is accepted on that edge, giving a 10-cycle throughput interval.
- ciphertext holds its value until the next completion. It is not cleared by start.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11b, per FIPS-197 5.1.3. ShiftRows rotates row r left by r bytes.
- word and key_ready are not registered inside the block.
  - Upstream must keep word stable from acceptance until done.
  - If key_ready falls during RUN, the round still completes. The result is undefined but the handshake is unaffected.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced.
- All state changes occur on the rising clk edge only, apart from the asynchronous reset.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: word from key expansion of 2b7e151628aed2a6abf7158809cf4f3c (rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6); start with plaintext 3243f6a8885a308d313198a2e0370734.
  - Response: after 10 cycles, done=1 for one cycle and ciphertext=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff.
  - Response: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; busy high for exactly 10 cycles.
- Gating:
  - Stimulus: start=1 with key_ready=0 for 5 cycles.
  - Response: busy stays 0, done stays 0, ciphertext stays 0.
  - Then raise key_ready. The next start is accepted.
- Busy drop plus back-to-back:
  - Stimulus: pulse start again at cycle 4 of RUN.
  - Response: it is ignored; only one done pulse occurs.
  - Stimulus: hold start high in the done cycle with the C.1 plaintext after the App. B run.
  - Response: second done exactly 10 cycles later with 69c4e0d8... (same C.1 key loaded).
- Reset mid-run:
  - Stimulus: assert rst_n=0 asynchronously at round 6, then release.
  - Response: busy=0, done=0, ciphertext=0 immediately with no pulse. A subsequent App. B run gives the correct result.
- Plaintext hold:
  - Stimulus: change plaintext to all ones one cycle after acceptance.
  - Response: ciphertext still 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_round_core.sv
// Iterative AES-128 encryption core: one round per clock, start/done handshake,
// SubBytes built from four 32-bit subword S-box slices.

module aes_subword (
  input  logic [31:0] w,
  output logic [31:0] sw
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    sw = '0;
    for (int i = 0; i < 4; i++) sw[8*i +: 8] = sbox(w[8*i +: 8]);
  end
endmodule

module aes_round_core #(
  parameter int unsigned NR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [0:1407]   word,
  input  logic            key_ready,
  input  logic            start,
  input  logic [0:127]    plaintext,
  output logic            busy,
  output logic [0:127]    ciphertext,
  output logic            done
);
  localparam int unsigned BW = 128;
  localparam int unsigned RW = 4;

  if (NR != 10) begin : g_nr_check
    $error("aes_round_core supports only NR=10");
  end

  typedef enum logic {S_IDLE, S_RUN} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [RW-1:0] round_q, round_d;
  logic [0:BW-1] state_q, state_d;
  logic [0:BW-1] ct_q, ct_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]   sb_col [4];
  logic [0:BW-1] sb_c, sr_c, mc_c, rk_c;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State byte index is row + 4*column; row r rotates left by r.
  function automatic logic [0:BW-1] shift_rows(input logic [0:BW-1] s);
    logic [0:BW-1] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:BW-1] mix_columns(input logic [0:BW-1] s);
    logic [0:BW-1] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_sbox
    aes_subword u_subword (
      .w  (state_q[32*c +: 32]),
      .sw (sb_col[c])
    );
  end

  // round_q is 0 in IDLE, so the same lookup supplies rk0 at acceptance.
  always_comb begin
    sb_c = '0;
    for (int c = 0; c < 4; c++) sb_c[32*c +: 32] = sb_col[c];
    sr_c = shift_rows(sb_c);
    mc_c = mix_columns(sr_c);
    rk_c = word[BW*32'(round_q) +: BW];
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start && key_ready) begin
          state_d = plaintext ^ rk_c;
          round_d = RW'(1);
          busy_d  = 1'b1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (round_q == RW'(NR)) begin
          ct_d    = sr_c ^ rk_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          round_d = '0;
          fsm_d   = S_IDLE;
        end else begin
          state_d = mc_c ^ rk_c;
          round_d = round_q + RW'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign ciphertext = ct_q;
  assign done       = done_q;
endmodule

// File: tb/tb_aes_round_core.sv
// Bench for aes_round_core: known-answer vectors, handshake gating, back-to-back,
// mid-run reset and plaintext hold.

module tb_aes_round_core;
  logic          clk;
  logic          rst_n;
  logic [0:1407] word;
  logic          key_ready;
  logic          start;
  logic [0:127]  plaintext;
  logic          busy;
  logic [0:127]  ciphertext;
  logic          done;

  aes_round_core #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word       (word),
    .key_ready  (key_ready),
    .start      (start),
    .plaintext  (plaintext),
    .busy       (busy),
    .ciphertext (ciphertext),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sbox_t [256];
  logic         done_prev = 1'b0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box table from the generator walk (p over powers of 3, q its inverse).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [0:1407] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1407] o;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  // Scoreboard: every done pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (ciphertext !== e) begin
          errors++;
          $display("FAIL ciphertext: got %h expected %h", ciphertext, e);
        end
      end
      if (done_prev) begin
        errors++;
        $display("FAIL done_width: got done high on consecutive cycles expected one-cycle pulse");
      end
    end
    done_prev = rst_n && done;
  end

  // Drops start after the accepting edge and measures latency/busy length.
  task automatic wait_done(input string name);
    int got;
    int bcnt;
    got  = 0;
    bcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        got = k;
        break;
      end
    end
    chk({name, "_latency"}, 128'(got - 1), 128'd10);
    chk({name, "_busy_cycles"}, 128'(bcnt), 128'd10);
  endtask

  vec_t vecs [4];
  logic [0:1407] wb;

  initial begin
    vecs[0] = '{KEY_B, PT_B, CT_B};
    vecs[1] = '{KEY_C, PT_C, CT_C};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};

    rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; word = '0; plaintext = '0;
    build_sbox();
    wb = expand(KEY_B);
    chk("model_rk10", wb[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_ct", ciphertext, 128'h0);
    rst_n = 1'b1;

    // start held while key not ready must be ignored
    word = wb; plaintext = PT_B; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gate_state", {busy, done, ciphertext}, 128'h0);
    end
    key_ready = 1'b1;
    exp_q.push_back(CT_B);

    // plaintext changes after acceptance, extra start mid-run is dropped
    begin
      int got;
      int bcnt;
      got = 0; bcnt = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) begin start = 1'b0; plaintext = '1; end
        if (k == 4) start = 1'b1;
        if (k == 5) start = 1'b0;
        if (busy) bcnt++;
        if (done) begin got = k; break; end
      end
      chk("gate_latency", 128'(got - 1), 128'd10);
      chk("gate_busy_cycles", 128'(bcnt), 128'd10);
    end

    // back-to-back: start held in the done cycle with a new key
    word = expand(KEY_C); plaintext = PT_C; start = 1'b1;
    exp_q.push_back(CT_C);
    wait_done("b2b");

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      word = expand(vecs[i].key); plaintext = vecs[i].pt; start = 1'b1;
      exp_q.push_back(vecs[i].ct);
      wait_done($sformatf("vec%0d", i));
    end
    repeat (3) @(negedge clk);
    chk("ct_hold", ciphertext, vecs[3].ct);

    // asynchronous reset at round 6
    word = wb; plaintext = PT_B; start = 1'b1;
    exp_q.push_back(CT_B);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("pre_reset_busy", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset", {busy, done, ciphertext}, 128'h0);
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_hold", {busy, done, ciphertext}, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(CT_B);
    wait_done("post_reset");
    repeat (2) @(negedge clk);
    chk("pending_results", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
